// File: rtl/fetch_unit.sv
// LEGv8 instruction fetch stage: PC, one-outstanding-request memory port,
// one-word skid buffer, and branch resolution with wrong-path drain.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_uncond,
  input  logic        br_reg,
  input  logic        br_lt,
  input  logic        br_cbz,
  input  logic        flag_n,
  input  logic        flag_v,
  input  logic        alu_zero,
  input  logic [63:0] br_pc,
  input  logic [63:0] br_offset,
  input  logic [63:0] br_reg_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [10:0] if_opcode,
  output logic [63:0] if_pc,
  output logic [63:0] if_pc_plus4,
  output logic        redirect,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [63:0] pc;
  logic [63:0] drain_addr;
  logic [31:0] skid_instr;
  logic [63:0] skid_pc;
  logic        taken;
  logic [63:0] target_raw;
  logic [63:0] target;
  logic        ack;

  always_comb begin
    taken = br_valid & (br_uncond | br_reg | (br_lt & (flag_n ^ flag_v)) | (br_cbz & alu_zero));
    target_raw = br_reg ? br_reg_target : br_pc + (br_offset << 2);
    target = {target_raw[63:2], 2'b00};
  end

  // Handshake: imem_req stays high with imem_addr frozen until imem_ack; an
  // ack is only honoured while a request is outstanding (REQ or DRAIN).
  assign ack         = imem_ack & (state != S_FULL);
  assign imem_req    = rst_n & (state != S_FULL);
  // In DRAIN the pc already holds the redirect target; the old address stays on the bus.
  assign imem_addr   = (state == S_DRAIN) ? drain_addr : pc;
  assign redirect    = taken;
  assign if_opcode   = if_instr[31:21];
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= {RESET_PC[63:2], 2'b00};
      drain_addr  <= 64'h0;
      skid_instr  <= 32'h0;
      skid_pc     <= 64'h0;
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 64'h0;
      if_pc_plus4 <= 64'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (taken) begin
            if_valid <= 1'b0;
            pc       <= target;
            if (!ack) begin
              drain_addr <= pc;
              state      <= S_DRAIN;
            end
          end else if (ack) begin
            pc <= pc + 64'd4;
            if (!if_valid || !stall) begin
              if_valid    <= 1'b1;
              if_instr    <= imem_rdata;
              if_pc       <= pc;
              if_pc_plus4 <= pc + 64'd4;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= S_FULL;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        S_FULL: begin
          if (taken) begin
            if_valid <= 1'b0;
            pc       <= target;
            state    <= S_REQ;
          end else if (!stall) begin
            if_valid    <= 1'b1;
            if_instr    <= skid_instr;
            if_pc       <= skid_pc;
            if_pc_plus4 <= skid_pc + 64'd4;
            state       <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (taken) begin
            if_valid <= 1'b0;
            pc       <= target;
          end
          if (ack) state <= S_REQ;
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, stall/skid, branches,
// wrong-path drain, and asynchronous reset during a drain.
module tb_fetch_unit;

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        br_valid, br_uncond, br_reg, br_lt, br_cbz;
  logic        flag_n, flag_v, alu_zero;
  logic [63:0] br_pc, br_offset, br_reg_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [10:0] if_opcode;
  logic [63:0] if_pc, if_pc_plus4;
  logic        redirect;
  logic [1:0]  fsm_state;

  int checks;
  int errors;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall),
    .br_valid(br_valid), .br_uncond(br_uncond), .br_reg(br_reg), .br_lt(br_lt), .br_cbz(br_cbz),
    .flag_n(flag_n), .flag_v(flag_v), .alu_zero(alu_zero),
    .br_pc(br_pc), .br_offset(br_offset), .br_reg_target(br_reg_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .redirect(redirect), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [63:0] a);
    logic [63:0] w;
    w = a >> 2;
    return 32'h91000421 + w[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_br();
    br_valid = 0; br_uncond = 0; br_reg = 0; br_lt = 0; br_cbz = 0;
    flag_n = 0; flag_v = 0; alu_zero = 0;
    br_pc = 64'h0; br_offset = 64'h0; br_reg_target = 64'h0;
  endtask

  task automatic drive_mem(input logic ack);
    imem_ack   = ack;
    imem_rdata = ack ? word_at(imem_addr) : 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    clear_br();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 64'h0 || if_pc_plus4 !== 64'h0) begin errors++; $display("FAIL reset_pc got %h/%h want 0/0", if_pc, if_pc_plus4); end
    checks++; if (fsm_state !== S_REQ) begin errors++; $display("FAIL reset_state got %0d want %0d", fsm_state, S_REQ); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL reset_release got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp_pc [4];
    logic [31:0] exp_in [4];
    exp_pc = '{64'h0, 64'h4, 64'h8, 64'hc};
    exp_in = '{32'h91000421, 32'h91000422, 32'h91000423, 32'h91000424};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_mem(1'b1);
      tick();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, if_valid); end
      checks++; if (if_pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d] got %h want %h", i, if_pc, exp_pc[i]); end
      checks++; if (if_instr !== exp_in[i]) begin errors++; $display("FAIL seq_instr[%0d] got %h want %h", i, if_instr, exp_in[i]); end
      checks++; if (if_opcode !== 11'h488) begin errors++; $display("FAIL seq_opcode[%0d] got %h want 488", i, if_opcode); end
      checks++; if (if_pc_plus4 !== exp_pc[i] + 64'd4) begin errors++; $display("FAIL seq_pc4[%0d] got %h want %h", i, if_pc_plus4, exp_pc[i] + 64'd4); end
      checks++; if (imem_addr !== exp_pc[i] + 64'd4) begin errors++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, exp_pc[i] + 64'd4); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_mem(1'b1); tick();
    drive_mem(1'b1); tick();
    stall = 1'b1;
    drive_mem(1'b1); tick();
    checks++; if (if_pc !== 64'h4 || if_instr !== 32'h91000422) begin errors++; $display("FAIL stall_hold got pc=%h instr=%h want 4/91000422", if_pc, if_instr); end
    checks++; if (fsm_state !== S_FULL) begin errors++; $display("FAIL stall_state got %0d want %0d", fsm_state, S_FULL); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_req); end
    drive_mem(1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1 || if_pc !== 64'h4 || fsm_state !== S_FULL) begin errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h st=%0d want 1/4/%0d", i, if_valid, if_pc, fsm_state, S_FULL); end
    end
    stall = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8 || if_instr !== 32'h91000423) begin errors++; $display("FAIL stall_release got v=%b pc=%h instr=%h want 1/8/91000423", if_valid, if_pc, if_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'hc || fsm_state !== S_REQ) begin errors++; $display("FAIL stall_rereq got req=%b addr=%h st=%0d want 1/c/0", imem_req, imem_addr, fsm_state); end
    drive_mem(1'b0);
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble got %b want 0", if_valid); end
  endtask

  task automatic test_branch_b();
    do_reset();
    drive_mem(1'b1); tick();
    br_valid = 1; br_uncond = 1; br_pc = 64'h10; br_offset = -64'sd2;
    drive_mem(1'b1);
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL b_redirect got %b want 1", redirect); end
    tick();
    clear_br();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 64'h8 || fsm_state !== S_REQ) begin errors++; $display("FAIL b_target got v=%b addr=%h st=%0d want 0/8/0", if_valid, imem_addr, fsm_state); end
    drive_mem(1'b1); tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h8 || if_instr !== 32'h91000423) begin errors++; $display("FAIL b_fetch got v=%b pc=%h instr=%h want 1/8/91000423", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_cond_branch();
    do_reset();
    drive_mem(1'b1); tick();
    br_valid = 1; br_lt = 1; flag_n = 1; flag_v = 0; br_pc = 64'h20; br_offset = 64'h10;
    drive_mem(1'b1);
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL blt_taken got %b want 1", redirect); end
    tick();
    checks++; if (imem_addr !== 64'h60 || if_valid !== 1'b0) begin errors++; $display("FAIL blt_target got addr=%h v=%b want 60/0", imem_addr, if_valid); end
    flag_n = 1; flag_v = 1;
    drive_mem(1'b1);
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL blt_not_taken got %b want 0", redirect); end
    tick();
    checks++; if (if_pc !== 64'h60 || imem_addr !== 64'h64) begin errors++; $display("FAIL blt_seq got pc=%h addr=%h want 60/64", if_pc, imem_addr); end
    clear_br();
    br_valid = 1; br_cbz = 1; alu_zero = 0; br_pc = 64'h60; br_offset = 64'h8;
    drive_mem(1'b1);
    #1;
    checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL cbz_not_taken got %b want 0", redirect); end
    tick();
    checks++; if (if_pc !== 64'h64 || imem_addr !== 64'h68) begin errors++; $display("FAIL cbz_seq got pc=%h addr=%h want 64/68", if_pc, imem_addr); end
    alu_zero = 1;
    #1;
    checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL cbz_taken got %b want 1", redirect); end
    clear_br();
  endtask

  task automatic test_br_drain();
    do_reset();
    drive_mem(1'b1); tick();
    br_valid = 1; br_reg = 1; br_uncond = 1; br_reg_target = 64'h1000; br_pc = 64'h40; br_offset = 64'h5;
    drive_mem(1'b0);
    tick();
    clear_br();
    checks++; if (fsm_state !== S_DRAIN || imem_req !== 1'b1 || imem_addr !== 64'h4) begin errors++; $display("FAIL drain_enter got st=%0d req=%b addr=%h want 2/1/4", fsm_state, imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", if_valid); end
    tick();
    checks++; if (imem_addr !== 64'h4) begin errors++; $display("FAIL drain_hold got addr=%h want 4", imem_addr); end
    drive_mem(1'b1); tick();
    checks++; if (if_valid !== 1'b0 || imem_addr !== 64'h1000 || fsm_state !== S_REQ) begin errors++; $display("FAIL drain_drop got v=%b addr=%h st=%0d want 0/1000/0", if_valid, imem_addr, fsm_state); end
    drive_mem(1'b1); tick();
    checks++; if (if_pc !== 64'h1000 || if_instr !== word_at(64'h1000)) begin errors++; $display("FAIL drain_fetch got pc=%h instr=%h want 1000/91000821", if_pc, if_instr); end
    br_valid = 1; br_reg = 1; br_reg_target = 64'h2002;
    drive_mem(1'b1); tick();
    clear_br();
    checks++; if (imem_addr !== 64'h2000) begin errors++; $display("FAIL br_align got addr=%h want 2000", imem_addr); end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    drive_mem(1'b1); tick();
    br_valid = 1; br_reg = 1; br_reg_target = 64'h3000;
    drive_mem(1'b0);
    tick();
    clear_br();
    stall = 1'b1;
    tick();
    checks++; if (fsm_state !== S_DRAIN) begin errors++; $display("FAIL rstdrain_pre got st=%0d want 2", fsm_state); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0 || fsm_state !== S_REQ) begin errors++; $display("FAIL rstdrain_async got v=%b req=%b st=%0d want 0/0/0", if_valid, imem_req, fsm_state); end
    tick();
    rst_n = 1'b1;
    stall = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin errors++; $display("FAIL rstdrain_restart got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    drive_mem(1'b1); tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 64'h0 || if_instr !== 32'h91000421) begin errors++; $display("FAIL rstdrain_fetch got v=%b pc=%h instr=%h want 1/0/91000421", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    stall = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    clear_br();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_b();
    test_cond_branch();
    test_br_drain();
    test_reset_in_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the LEGv8 datapath. Holds the PC, issues one-outstanding-request reads to instruction memory and presents the fetched word, its PC and PC+4 to decode/control, where `if_opcode` drives the control unit's opcode input. Resolves taken branches (B, BL, BR, B.LT, CBZ) from decode/execute control signals and redirects fetch, flushing and discarding wrong-path words.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request; held high with `imem_addr` stable until `imem_ack`.
- `imem_addr`  out  64  word-aligned fetch address.
- `imem_ack`  in  1  read complete; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept; hold outputs.
- `br_valid`  in  1  branch resolution valid this cycle.
- `br_uncond`, `br_reg`, `br_lt`, `br_cbz`  in  1 each  UncondBranch, BranchRegister, CheckForLT, CBZ-type from control.
- `flag_n`, `flag_v`, `alu_zero`  in  1 each  flags for B.LT / CBZ.
- `br_pc`  in  64  PC of branch instruction.
- `br_offset`  in  64  sign-extended word offset (imm26 or imm19).
- `br_reg_target`  in  64  Rn value for BR.
- `if_valid`  out  1  output word valid.
- `if_instr`  out  32  fetched instruction.
- `if_opcode`  out  11  `if_instr[31:21]`.
- `if_pc`, `if_pc_plus4`  out  64 each  PC of word; link value for BL.
- `redirect`  out  1  taken branch accepted this cycle (combinational).

## Operation
- taken = br_valid & (br_uncond | br_reg | (br_lt & (flag_n ^ flag_v)) | (br_cbz & alu_zero)); `redirect` = taken.
- target = br_reg ? br_reg_target : br_pc + (br_offset << 2); 64-bit wrap-around, no overflow detection. br_reg takes priority over br_uncond.
- States: REQ (imem_req=1, addr=pc), FULL (word held in skid buffer, imem_req=0), DRAIN (wrong-path request outstanding, imem_req=1 with old addr).
- REQ, ack, no redirect: if `!if_valid | !stall` load output regs (if_valid=1, instr, pc, pc+4), pc<=pc+4, stay REQ; else write skid, pc<=pc+4, go FULL.
- REQ, no ack, no redirect: hold; if `!stall` clear if_valid.
- FULL: when `!stall`, skid -> output regs, go REQ.
- Redirect (any state): if_valid<=0, skid invalidated, pc<=target. REQ+ack or FULL -> REQ; REQ without ack -> DRAIN; DRAIN stays DRAIN.
- DRAIN: on ack discard data, go REQ (new pc). Redirect in same cycle as DRAIN ack: pc<=new target, go REQ.
- Redirect beats stall and ack. Never more than one outstanding request; imem_addr never changes while imem_req high and no ack.
- imem_addr[1:0] always 0; target low bits forced to 0.

## Timing
- Reset (async, rst_n low): pc=RESET_PC, state=REQ, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, skid empty; imem_req=0 while rst_n low, 1 from first cycle after release.
- Latency: ack in cycle N -> if_valid/if_instr visible N+1. Zero-wait memory (ack every cycle) sustains one instruction per cycle.
- Redirect in cycle N -> imem_addr=target from N+1 (or first cycle after DRAIN ack); if_valid=0 at N+1.
- Stall release in FULL at cycle N -> skid word on outputs N+1, new request from N+1.

## Test plan
- Reset, ack every cycle, words 0x91000421.. -> if_pc 0,4,8,12 on consecutive cycles, if_opcode = instr[31:21], if_pc_plus4 = if_pc+4.
- stall=1 for 3 cycles while ack returns word at pc=8 -> outputs hold pc=4 word, state FULL, imem_req=0; stall drop -> pc=8 word next cycle, then request to 12.
- B with br_pc=0x10, br_offset=-2 -> redirect=1, next imem_addr=0x8, if_valid=0 next cycle; wrong-path ack discarded.
- B.LT with flag_n=1, flag_v=0 taken to br_pc+0x40; with flag_n=flag_v=1 not taken, sequential fetch continues. CBZ alu_zero=0 not taken.
- BR with br_reg_target=0x1000 while request outstanding without ack -> DRAIN, imem_addr stays old until ack, data dropped, then imem_addr=0x1000.
- rst_n asserted mid-DRAIN with stall=1 -> immediately if_valid=0, imem_req=0; after release fetch restarts at RESET_PC.
